// File: rtl/tpu_cfu_bridge.sv
// ============================================================================
// tpu_cfu_bridge: CFU command initiator for the TPU funct-code interface.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tpu_cfu_bridge #(
   parameter int C_ROWS       = 4,
   parameter int DONE_SETTLE  = 2,
   parameter int READ_WAIT    = 2,
   parameter int COMP_TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_function_id,
   input  logic [31:0] cmd_inputs_0,
   input  logic [31:0] cmd_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_outputs_0,
   output logic [2:0]  tpu_funct,
   output logic [31:0] tpu_in0,
   output logic [31:0] tpu_in1,
   input  logic [15:0] tpu_c_idx,
   input  logic [31:0] tpu_cout
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_COMP = 3'd2,
      S_SETTLE    = 3'd3,
      S_WAIT_READ = 3'd4,
      S_RESP      = 3'd5
   } state_t;

   localparam logic [2:0]  OP_STATUS = 3'd0;
   localparam logic [2:0]  OP_CFG    = 3'd1;
   localparam logic [2:0]  OP_LOAD   = 3'd2;
   localparam logic [2:0]  OP_READ   = 3'd3;
   localparam logic [2:0]  OP_CLEAR  = 3'd4;
   localparam logic [2:0]  OP_COMP   = 3'd6;
   localparam logic [15:0] LAST_ROW  = 16'(C_ROWS - 1);

   state_t      state_q;
   logic [2:0]  op_q;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_data_q;
   logic [2:0]  funct_q;
   logic [31:0] in0_q;
   logic [31:0] in1_q;
   logic [15:0] cyc_q;
   logic [15:0] cnt_q;
   logic        armed_q;

   logic [15:0] cyc_d;
   logic        done_d;
   logic        timeout_d;
   logic        settle_end_d;
   logic        read_end_d;
   logic        pulse_op_d;
   logic        unused_fid;

   // Only the low three bits carry the op; the rest of the function id is don't-care.
   assign unused_fid = ^cmd_function_id[9:3];

   assign cyc_d        = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
   assign done_d       = armed_q && (tpu_c_idx == LAST_ROW);
   assign timeout_d    = 32'(cyc_d) >= 32'(COMP_TIMEOUT);
   assign settle_end_d = (32'(cnt_q) + 32'd1) >= 32'(DONE_SETTLE);
   assign read_end_d   = (32'(cnt_q) + 32'd1) >= 32'(READ_WAIT);

   always_comb begin
      pulse_op_d = 1'b0;
      case (cmd_function_id[2:0])
         OP_CFG, OP_LOAD, OP_READ, OP_CLEAR, OP_COMP: pulse_op_d = 1'b1;
         default:                                     pulse_op_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= 3'd0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         funct_q     <= 3'd0;
         in0_q       <= 32'd0;
         in1_q       <= 32'd0;
         cyc_q       <= 16'd0;
         cnt_q       <= 16'd0;
         armed_q     <= 1'b0;
      end else begin
         // The funct pulse lasts exactly the ISSUE cycle.
         funct_q <= 3'd0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q        <= cmd_function_id[2:0];
                  in0_q       <= cmd_inputs_0;
                  in1_q       <= cmd_inputs_1;
                  funct_q     <= pulse_op_d ? cmd_function_id[2:0] : 3'd0;
                  cmd_ready_q <= 1'b0;
                  cyc_q       <= 16'd0;
                  cnt_q       <= 16'd0;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cyc_q   <= cyc_d;
               armed_q <= (tpu_c_idx != LAST_ROW);
               case (op_q)
                  OP_CFG, OP_LOAD, OP_CLEAR: begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= 32'd0;
                     state_q     <= S_RESP;
                  end
                  OP_COMP:  state_q <= S_WAIT_COMP;
                  OP_READ:  state_q <= S_WAIT_READ;
                  OP_STATUS: begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= {16'd0, tpu_c_idx};
                     state_q     <= S_RESP;
                  end
                  default: begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= 32'hDEAD_BEEF;
                     state_q     <= S_RESP;
                  end
               endcase
            end
            S_WAIT_COMP: begin
               cyc_q <= cyc_d;
               if (done_d) begin
                  cnt_q <= 16'd0;
                  if (DONE_SETTLE == 0) begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= {16'd0, cyc_d};
                     state_q     <= S_RESP;
                  end else begin
                     state_q <= S_SETTLE;
                  end
               end else if (timeout_d) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= {1'b1, 15'd0, cyc_d};
                  state_q     <= S_RESP;
               end else if (tpu_c_idx != LAST_ROW) begin
                  armed_q <= 1'b1;
               end
            end
            S_SETTLE: begin
               cyc_q <= cyc_d;
               if (settle_end_d) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= {16'd0, cyc_d};
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_WAIT_READ: begin
               if (read_end_d) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= tpu_cout;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_outputs_0 = rsp_data_q;
   assign tpu_funct     = funct_q;
   assign tpu_in0       = in0_q;
   assign tpu_in1       = in1_q;

endmodule

`default_nettype wire

// File: tb/tb_tpu_cfu_bridge.sv
// ============================================================================
// tb_tpu_cfu_bridge: directed bench with a response scoreboard and TPU stub.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tpu_cfu_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_function_id;
   logic [31:0] cmd_inputs_0;
   logic [31:0] cmd_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_outputs_0;
   logic [2:0]  tpu_funct;
   logic [31:0] tpu_in0;
   logic [31:0] tpu_in1;
   logic [15:0] tpu_c_idx;
   logic [31:0] tpu_cout;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [2:0]  prev_f = 3'd0;

   always #5 clk = ~clk;

   tpu_cfu_bridge dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_function_id (cmd_function_id),
      .cmd_inputs_0    (cmd_inputs_0),
      .cmd_inputs_1    (cmd_inputs_1),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_outputs_0   (rsp_outputs_0),
      .tpu_funct       (tpu_funct),
      .tpu_in0         (tpu_in0),
      .tpu_in1         (tpu_in1),
      .tpu_c_idx       (tpu_c_idx),
      .tpu_cout        (tpu_cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // funct must never be nonzero on two consecutive cycles
   always @(negedge clk) begin
      if (prev_f != 3'd0) chk("pulse_width", {29'd0, tpu_funct}, 32'd0);
      prev_f = tpu_funct;
   end

   // Returns just after the accepting posedge.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      @(negedge clk);
      cmd_valid       = 1'b1;
      cmd_function_id = {7'h55, op};
      cmd_inputs_0    = a;
      cmd_inputs_1    = b;
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag, input int budget);
      int          n = 0;
      logic [31:0] exp;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      while (rsp_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_data"}, rsp_outputs_0, exp);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n           = 1'b0;
      cmd_valid       = 1'b0;
      cmd_function_id = 10'd0;
      cmd_inputs_0    = 32'd0;
      cmd_inputs_1    = 32'd0;
      rsp_ready       = 1'b0;
      tpu_c_idx       = 16'd0;
      tpu_cout        = 32'd0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_outputs_0, 32'd0);
      chk("rst_funct", {29'd0, tpu_funct}, 32'd0);
      chk("rst_in0", tpu_in0, 32'd0);
      chk("rst_in1", tpu_in1, 32'd0);
      rst_n = 1'b1;

      // Reset in the middle of a compute aborts it
      send(3'd6, 32'hA5A5_0001, 32'h0000_0002);
      repeat (10) @(negedge clk);
      chk("comp_busy", {31'd0, cmd_ready}, 32'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_funct", {29'd0, tpu_funct}, 32'd0);
      chk("abort_in0", tpu_in0, 32'd0);

      // Config: exact pulse and response timing
      send(3'd1, 32'd16, 32'd128);
      exp_q.push_back(32'd0);
      @(negedge clk);
      chk("cfg_funct", {29'd0, tpu_funct}, 32'd1);
      chk("cfg_in0", tpu_in0, 32'd16);
      chk("cfg_in1", tpu_in1, 32'd128);
      chk("cfg_rsp_early", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("cfg_funct_off", {29'd0, tpu_funct}, 32'd0);
      chk("cfg_rsp_ontime", {31'd0, rsp_valid}, 32'd1);
      get_rsp("cfg", 10);
      @(negedge clk);
      chk("cfg_ready_back", {31'd0, cmd_ready}, 32'd1);
      chk("cfg_in0_hold", tpu_in0, 32'd16);

      // Sixteen loads, then a compute finishing 20 cycles after accept
      for (int i = 0; i < 16; i++) begin
         send(3'd2, 32'(i), 32'(i * 3 + 7));
         exp_q.push_back(32'd0);
         @(negedge clk);
         chk("load_funct", {29'd0, tpu_funct}, 32'd2);
         chk("load_in0", tpu_in0, 32'(i));
         get_rsp("load", 10);
      end
      tpu_c_idx = 16'd0;
      send(3'd6, 32'd0, 32'd0);
      exp_q.push_back(32'd22);
      @(negedge clk);
      chk("comp_funct", {29'd0, tpu_funct}, 32'd6);
      repeat (19) @(posedge clk);
      #1 tpu_c_idx = 16'd3;
      get_rsp("comp_done", 50);
      tpu_c_idx = 16'd0;

      // Compute that never completes
      send(3'd6, 32'd0, 32'd0);
      exp_q.push_back(32'h8000_1000);
      get_rsp("comp_timeout", 5000);

      // Read C word
      tpu_cout = 32'h1234_5678;
      send(3'd3, 32'd2, 32'd1);
      exp_q.push_back(32'h1234_5678);
      @(negedge clk);
      chk("rd_funct", {29'd0, tpu_funct}, 32'd3);
      chk("rd_in0", tpu_in0, 32'd2);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rd_in1_hold", tpu_in1, 32'd1);
         chk("rd_rsp_early", {31'd0, rsp_valid}, 32'd0);
      end
      @(negedge clk);
      chk("rd_rsp_ontime", {31'd0, rsp_valid}, 32'd1);
      get_rsp("rd", 10);

      // Status with the CPU stalling the response
      tpu_c_idx = 16'd2;
      send(3'd0, 32'd9, 32'd9);
      exp_q.push_back(32'd2);
      @(negedge clk);
      chk("status_nopulse", {29'd0, tpu_funct}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_data", rsp_outputs_0, 32'd2);
         chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      tpu_c_idx = 16'd0;
      get_rsp("status", 10);

      // Reserved ops: no pulse, fixed marker
      send(3'd5, 32'd1, 32'd1);
      exp_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk("op5_nopulse", {29'd0, tpu_funct}, 32'd0);
      get_rsp("op5", 10);
      send(3'd7, 32'd1, 32'd1);
      exp_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk("op7_nopulse", {29'd0, tpu_funct}, 32'd0);
      get_rsp("op7", 10);

      // Clear
      send(3'd4, 32'h0BAD_F00D, 32'd5);
      exp_q.push_back(32'd0);
      @(negedge clk);
      chk("clr_funct", {29'd0, tpu_funct}, 32'd4);
      chk("clr_in0", tpu_in0, 32'h0BAD_F00D);
      get_rsp("clr", 10);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
